kyber_zeta_stream: RTL and testbench
====================================

# kyber_zeta_stream

Parametrised twiddle-factor server for the Kyber NTT/INTT datapath. It holds the table of powers ROOT^i mod Q, 2^LOG_N entries, built at elaboration. It walks the full butterfly schedule of a forward or inverse transform and streams one zeta per butterfly beat under valid/ready backpressure. It sits between the NTT controller and the butterfly unit and replaces direct address-driven zeta ROM lookups.

## Interface
- DATA_W, 12, zeta width; must hold Q-1.
- Q, 3329, modulus.
- ROOT, 17, primitive 2^LOG_N-th root of unity mod Q.
- LOG_N, 8, log2 of the table depth. The polynomial has N=2^LOG_N coefficients and N/2 butterflies per layer.
- LAYERS, 7, number of NTT layers. Minimum len is 2^(LOG_N-LAYERS).
- LANES, 1, butterflies covered per beat. Must be a power of 2 and ≤ 2^(LOG_N-LAYERS).

- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high reset.
- i_start, in, 1, start pulse; accepted only in IDLE.
- i_inv, in, 1, sampled with i_start: 0 selects NTT, 1 selects INTT.
- i_abort, in, 1, synchronous flush back to IDLE.
- i_ready, in, 1, consumer ready.
- o_valid, out, 1, o_zeta valid.
- o_zeta, out, DATA_W, twiddle factor.
- o_k, out, LAYERS, group index k of the current beat.
- o_layer, out, 3, layer index l of the current beat.
- o_last, out, 1, final beat of the transform.
- o_busy, out, 1, high from start acceptance until o_done.
- o_done, out, 1, one-cycle completion pulse.

## Operation
- Table: T[i] = ROOT^i mod Q for i in 0..2^LOG_N-1. Synchronous-read ROM, computed by a constant function with no init file. With defaults, T[0]=1, T[1]=17, T[2]=289, T[3]=1584.
- brv(k) is k bit-reversed over LAYERS bits. len(l) = 2^(LOG_N-1-l). Each group emits len(l)/LANES beats, all with the same zeta.
- NTT schedule:
  - l = 0..LAYERS-1 ascending.
  - g = 0..2^l-1 ascending.
  - k = 2^l + g.
  - Zeta address = brv(k).
- INTT schedule:
  - l = LAYERS-1..0 descending.
  - g = 0..2^l-1 ascending.
  - k = 2^(l+1)-1-g.
  - Zeta address = (2^LOG_N - brv(k)) mod 2^LOG_N, i.e. ROOT^-brv(k). No second table.
- Total beats = LAYERS·N/(2·LANES): 896 for defaults, 448 when LANES=2.
- FSM states: IDLE -> RUN (addresses issued) -> DRAIN (all addresses issued, pipeline emptying) -> IDLE.
  - i_start in IDLE: latch i_inv, clear counters, enter RUN.
  - i_start outside IDLE: ignored.
  - i_abort in any state: IDLE next cycle. Clears pipeline and skid; o_valid=0; no o_done.
  - i_abort together with i_start in IDLE: abort wins.
- Pipeline:
  - Stage 1: address/k/l register.
  - Stage 2: ROM read.
  - Then a 2-entry skid buffer driving the outputs.
- Address issue stalls when the skid buffer cannot absorb the in-flight beats. No beat is ever dropped or duplicated.
- o_k, o_layer and o_last travel with their zeta.

## Timing
- Reset values of all outputs: 0. FSM resets to IDLE. Reset mid-transform aborts immediately, with no o_done.
- i_start at cycle t: o_busy=1 at t+1, first o_valid at t+3.
- With i_ready held high: one beat per cycle, no bubbles. The defaults finish the last handshake at t+3+895.
- When o_valid=1 and i_ready=0, o_zeta, o_k, o_layer and o_last hold stable.
- A beat transfers on o_valid && i_ready.
- Completion, the cycle after the o_last handshake:
  - o_done=1 for one cycle.
  - o_busy=0 in the same cycle.
  - i_start is accepted in that cycle.
- Counter wrap: group and layer counters advance only on address issue. The final issue moves the FSM to DRAIN and does not wrap.

## Configuration
- ZETA_RAW_PORT_EN defined: adds i_raw_req (1), i_raw_addr (LOG_N), o_raw_valid (1), o_raw_zeta (DATA_W) and o_raw_err (1).
  - i_raw_req in IDLE returns T[i_raw_addr] with o_raw_valid 2 cycles later.
  - i_raw_req while busy is dropped and o_raw_err pulses 1 cycle.
  - i_raw_req together with i_start in IDLE: both are served.
  - Raw outputs reset to 0.
- Not defined: the ports are absent and ROM reads come only from the stream.

## Test plan
- Defaults, NTT, i_ready=1:
  - Beats 0..127: zeta=1729, k=1, l=0.
  - Beat 128: zeta=2580, k=2.
  - Beat 192: zeta=3289, k=3.
  - Beat 895: zeta=2154, k=127, l=6, o_last=1.
  - o_done follows one cycle later; 896 beats total.
- INTT: beats 0,1: zeta=3312, k=127, l=6. The final 128 beats: zeta=T[192]=1600, k=1, l=0.
- Random i_ready toggling (≥30% low) across a full NTT:
  - Beat sequence identical to the i_ready=1 run.
  - Outputs stable while stalled.
  - Exactly one o_done.
- Mid-run events:
  - i_abort at beat 300: o_valid=0 next cycle, no o_done. A new i_start then yields first zeta 1729.
  - Async reset at beat 300: all outputs 0 immediately.
  - i_start pulsed while busy: no effect.
- LANES=2: 448 beats. Beats 0..63 zeta=1729. Last beat zeta=2154.
- ZETA_RAW_PORT_EN:
  - Raw addr 3 in IDLE -> o_raw_zeta=1584 two cycles later.
  - Raw addr 128 -> 3328.
  - Raw request during RUN -> o_raw_err pulse, stream unaffected.

Source files
------------

// File: rtl/kyber_zeta_stream_if.sv
// Handshake bundle between the NTT controller and kyber_zeta_stream.
// The raw lookup signals (and LOG_N) exist only when ZETA_RAW_PORT_EN is defined.
interface kyber_zeta_stream_if #(
  parameter int DATA_W = 12,
  parameter int LAYERS = 7
`ifdef ZETA_RAW_PORT_EN
  , parameter int LOG_N = 8
`endif
);
  logic              i_start;
  logic              i_inv;
  logic              i_abort;
  logic              i_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_zeta;
  logic [LAYERS-1:0] o_k;
  logic [2:0]        o_layer;
  logic              o_last;
  logic              o_busy;
  logic              o_done;
`ifdef ZETA_RAW_PORT_EN
  logic              i_raw_req;
  logic [LOG_N-1:0]  i_raw_addr;
  logic              o_raw_valid;
  logic [DATA_W-1:0] o_raw_zeta;
  logic              o_raw_err;
`endif

  modport master (
    output i_start, i_inv, i_abort, i_ready,
`ifdef ZETA_RAW_PORT_EN
    output i_raw_req, i_raw_addr,
    input  o_raw_valid, o_raw_zeta, o_raw_err,
`endif
    input  o_valid, o_zeta, o_k, o_layer, o_last, o_busy, o_done
  );

  modport slave (
    input  i_start, i_inv, i_abort, i_ready,
`ifdef ZETA_RAW_PORT_EN
    input  i_raw_req, i_raw_addr,
    output o_raw_valid, o_raw_zeta, o_raw_err,
`endif
    output o_valid, o_zeta, o_k, o_layer, o_last, o_busy, o_done
  );
endinterface

// File: rtl/kyber_zeta_stream.sv
// Twiddle-factor server: walks the NTT/INTT butterfly schedule and streams ROOT^i mod Q per beat.
// Optional raw table lookup port enabled by ZETA_RAW_PORT_EN.
module kyber_zeta_stream #(
  parameter int DATA_W = 12,
  parameter int Q      = 3329,
  parameter int ROOT   = 17,
  parameter int LOG_N  = 8,
  parameter int LAYERS = 7,
  parameter int LANES  = 1
) (
  input logic clk,
  input logic reset,
  kyber_zeta_stream_if.slave bus
);
  localparam int N         = 2 ** LOG_N;
  localparam int GRP_SHIFT = LOG_N - 1 - $clog2(LANES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] zeta;
    logic [LAYERS-1:0] k;
    logic [2:0]        layer;
    logic              last;
  } beat_t;

  function automatic logic [DATA_W-1:0] zeta_pow(input int unsigned e);
    longint p;
    p = 1;
    for (int unsigned i = 0; i < e; i++) p = (p * ROOT) % Q;
    return DATA_W'(p);
  endfunction

  logic [DATA_W-1:0] rom [N];
  for (genvar gi = 0; gi < N; gi++) begin : g_rom
    assign rom[gi] = zeta_pow(gi);
  end

  state_t            state_q, state_d;
  logic              inv_q, inv_d;
  logic [2:0]        l_q, l_d;
  logic [LAYERS-1:0] g_q, g_d;
  logic [LOG_N-1:0]  b_q, b_d;
  logic              s1_valid_q, s1_valid_d;
  logic [LOG_N-1:0]  s1_addr_q, s1_addr_d;
  logic [LAYERS-1:0] s1_k_q, s1_k_d;
  logic [2:0]        s1_l_q, s1_l_d;
  logic              s1_last_q, s1_last_d;
  logic              out_valid_q, out_valid_d;
  logic              sk_valid_q, sk_valid_d;
  beat_t             out_q, out_d, sk_q, sk_d, incoming;
  logic              busy_q, busy_d, done_q, done_d;

  logic [LAYERS-1:0] cur_k, rev;
  logic [LOG_N-1:0]  cur_addr;
  logic              grp_end, lay_end, fin_l, cur_last, pop, issue;
  logic [1:0]        occ;
  logic [DATA_W-1:0] rom_rd;

  always_comb begin
    cur_k = inv_q ? ((LAYERS'(2) << l_q) - LAYERS'(1) - g_q) : ((LAYERS'(1) << l_q) + g_q);
    rev = '0;
    for (int unsigned i = 0; i < LAYERS; i++) rev[i] = cur_k[LAYERS-1-i];
    cur_addr = inv_q ? (LOG_N'(0) - LOG_N'(rev)) : LOG_N'(rev);
    grp_end  = b_q == ((LOG_N'(1) << (8'(GRP_SHIFT) - 8'(l_q))) - LOG_N'(1));
    lay_end  = g_q == ((LAYERS'(1) << l_q) - LAYERS'(1));
    fin_l    = inv_q ? (l_q == '0) : (l_q == 3'(LAYERS - 1));
    cur_last = grp_end && lay_end && fin_l;
    pop      = out_valid_q && bus.i_ready;
    // Issue only if the beat can still land in the 2-entry buffer, counting the one already in stage 1.
    occ      = 2'(out_valid_q) + 2'(sk_valid_q) + 2'(s1_valid_q);
    issue    = (state_q == RUN) && (occ <= 2'(pop) + 2'd1);
    rom_rd   = rom[s1_addr_q];
    incoming = '{zeta: rom_rd, k: s1_k_q, layer: s1_l_q, last: s1_last_q};
  end

  always_comb begin
    state_d     = state_q;
    inv_d       = inv_q;
    l_d         = l_q;
    g_d         = g_q;
    b_d         = b_q;
    s1_valid_d  = issue;
    s1_addr_d   = s1_addr_q;
    s1_k_d      = s1_k_q;
    s1_l_d      = s1_l_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    sk_valid_d  = sk_valid_q;
    sk_d        = sk_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (issue) begin
      s1_addr_d = cur_addr;
      s1_k_d    = cur_k;
      s1_l_d    = l_q;
      s1_last_d = cur_last;
      if (cur_last) begin
        state_d = DRAIN;
      end else if (!grp_end) begin
        b_d = b_q + LOG_N'(1);
      end else begin
        b_d = '0;
        if (!lay_end) begin
          g_d = g_q + LAYERS'(1);
        end else begin
          g_d = '0;
          l_d = inv_q ? l_q - 3'd1 : l_q + 3'd1;
        end
      end
    end

    if ((pop && !sk_valid_q) || !out_valid_q) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_d = incoming;
    end else if (pop) begin
      out_d      = sk_q;
      sk_valid_d = s1_valid_q;
      if (s1_valid_q) sk_d = incoming;
    end else if (s1_valid_q) begin
      sk_valid_d = 1'b1;
      sk_d       = incoming;
    end

    if (state_q == IDLE && bus.i_start) begin
      state_d = RUN;
      inv_d   = bus.i_inv;
      l_d     = bus.i_inv ? 3'(LAYERS - 1) : '0;
      g_d     = '0;
      b_d     = '0;
      busy_d  = 1'b1;
    end else if (state_q == DRAIN && pop && out_q.last) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

    if (bus.i_abort) begin
      state_d     = IDLE;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      sk_valid_d  = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

`ifdef ZETA_RAW_PORT_EN
  logic              raw_s1_q, raw_s1_d;
  logic [LOG_N-1:0]  raw_addr_q, raw_addr_d;
  logic              raw_valid_q, raw_valid_d, raw_err_q, raw_err_d;
  logic [DATA_W-1:0] raw_zeta_q, raw_zeta_d;

  always_comb begin
    raw_s1_d    = bus.i_raw_req && (state_q == IDLE);
    raw_addr_d  = raw_s1_d ? bus.i_raw_addr : raw_addr_q;
    raw_valid_d = raw_s1_q;
    raw_zeta_d  = raw_s1_q ? rom[raw_addr_q] : raw_zeta_q;
    raw_err_d   = bus.i_raw_req && (state_q != IDLE);
  end

  assign bus.o_raw_valid = raw_valid_q;
  assign bus.o_raw_zeta  = raw_zeta_q;
  assign bus.o_raw_err   = raw_err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      inv_q       <= 1'b0;
      l_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_k_q      <= '0;
      s1_l_q      <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      sk_valid_q  <= 1'b0;
      sk_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ZETA_RAW_PORT_EN
      raw_s1_q    <= 1'b0;
      raw_addr_q  <= '0;
      raw_valid_q <= 1'b0;
      raw_zeta_q  <= '0;
      raw_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      inv_q       <= inv_d;
      l_q         <= l_d;
      g_q         <= g_d;
      b_q         <= b_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_k_q      <= s1_k_d;
      s1_l_q      <= s1_l_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      sk_valid_q  <= sk_valid_d;
      sk_q        <= sk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ZETA_RAW_PORT_EN
      raw_s1_q    <= raw_s1_d;
      raw_addr_q  <= raw_addr_d;
      raw_valid_q <= raw_valid_d;
      raw_zeta_q  <= raw_zeta_d;
      raw_err_q   <= raw_err_d;
`endif
    end
  end

  assign bus.o_valid = out_valid_q;
  assign bus.o_zeta  = out_q.zeta;
  assign bus.o_k     = out_q.k;
  assign bus.o_layer = out_q.layer;
  assign bus.o_last  = out_q.last;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
endmodule

// File: tb/tb_kyber_zeta_stream.sv
// Scoreboard bench for kyber_zeta_stream: expected beats come from an arithmetic schedule model.
module tb_kyber_zeta_stream;
  localparam int DATA_W = 12;
  localparam int Q      = 3329;
  localparam int ROOT   = 17;
  localparam int LOG_N  = 8;
  localparam int LAYERS = 7;
  localparam int N      = 2 ** LOG_N;
  localparam int BEATS  = LAYERS * N / 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kyber_zeta_stream_if #(.DATA_W(DATA_W), .LAYERS(LAYERS)
`ifdef ZETA_RAW_PORT_EN
    , .LOG_N(LOG_N)
`endif
  ) bus ();
  kyber_zeta_stream_if #(.DATA_W(DATA_W), .LAYERS(LAYERS)
`ifdef ZETA_RAW_PORT_EN
    , .LOG_N(LOG_N)
`endif
  ) bus2 ();

  kyber_zeta_stream #(.DATA_W(DATA_W), .Q(Q), .ROOT(ROOT), .LOG_N(LOG_N), .LAYERS(LAYERS), .LANES(1))
    u_dut (.clk(clk), .reset(reset), .bus(bus));
  kyber_zeta_stream #(.DATA_W(DATA_W), .Q(Q), .ROOT(ROOT), .LOG_N(LOG_N), .LAYERS(LAYERS), .LANES(2))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    int zeta;
    int k;
    int l;
    bit last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t me, me2;
  int    beat_idx = 0;
  int    done_cnt = 0;
  int    seen_z[BEATS];
  bit    expect_done = 0;
  bit    hold_v = 0;
  int    hz, hk, hl, hlast;
  int    cnt2 = 0, z2_first = 0, z2_last = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int pow_mod(input int e);
    longint p;
    p = 1;
    for (int i = 0; i < e; i++) p = (p * ROOT) % Q;
    return int'(p);
  endfunction

  function automatic int brv(input int k);
    int r;
    r = 0;
    for (int i = 0; i < LAYERS; i++) if (k[i]) r = r | (1 << (LAYERS - 1 - i));
    return r;
  endfunction

  // Beat idx of the transform, computed directly from layer/group arithmetic.
  function automatic beat_t model(input bit inv, input int lanes, input int idx);
    beat_t b;
    int per_layer, step, pos, l, gbeats, g, k, a;
    per_layer = N / (2 * lanes);
    step      = idx / per_layer;
    pos       = idx % per_layer;
    l         = inv ? LAYERS - 1 - step : step;
    gbeats    = (N >> (l + 1)) / lanes;
    g         = pos / gbeats;
    k         = inv ? (2 << l) - 1 - g : (1 << l) + g;
    a         = inv ? (N - brv(k)) % N : brv(k);
    b.zeta    = pow_mod(a);
    b.k       = k;
    b.l       = l;
    b.last    = (idx == LAYERS * per_layer - 1);
    return b;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      hold_v      = 0;
      expect_done = 0;
    end else begin
      if (expect_done) begin
        chk("done_pulse", int'(bus.o_done), 1);
        chk("busy_low_at_done", int'(bus.o_busy), 0);
        expect_done = 0;
      end
      if (bus.o_done) done_cnt++;
      if (hold_v && bus.o_valid) begin
        chk("stall_zeta", int'(bus.o_zeta), hz);
        chk("stall_k", int'(bus.o_k), hk);
        chk("stall_layer", int'(bus.o_layer), hl);
        chk("stall_last", int'(bus.o_last), hlast);
      end
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got zeta %0d, expected no beat", bus.o_zeta);
        end else begin
          me = exp_q.pop_front();
          chk("zeta", int'(bus.o_zeta), me.zeta);
          chk("k", int'(bus.o_k), me.k);
          chk("layer", int'(bus.o_layer), me.l);
          chk("last", int'(bus.o_last), int'(me.last));
          if (beat_idx < BEATS) seen_z[beat_idx] = int'(bus.o_zeta);
          beat_idx++;
          if (me.last) expect_done = 1;
        end
      end
      hold_v = bus.o_valid && !bus.i_ready;
      hz     = int'(bus.o_zeta);
      hk     = int'(bus.o_k);
      hl     = int'(bus.o_layer);
      hlast  = int'(bus.o_last);
    end
  end

  always @(negedge clk) begin
    if (!reset && bus2.o_valid && bus2.i_ready) begin
      me2 = model(1'b0, 2, cnt2);
      chk("l2_zeta", int'(bus2.o_zeta), me2.zeta);
      chk("l2_k", int'(bus2.o_k), me2.k);
      chk("l2_layer", int'(bus2.o_layer), me2.l);
      chk("l2_last", int'(bus2.o_last), int'(me2.last));
      if (cnt2 == 0) z2_first = int'(bus2.o_zeta);
      z2_last = int'(bus2.o_zeta);
      cnt2++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_sched(input bit inv);
    exp_q.delete();
    for (int i = 0; i < BEATS; i++) exp_q.push_back(model(inv, 1, i));
    beat_idx = 0;
  endtask

  task automatic run_full(input bit inv, input int low_pct, input bit poke);
    int n, done0;
    done0 = done_cnt;
    load_sched(inv);
    bus.i_start = 1'b1;
    bus.i_inv   = inv;
    tick();
    n = 1;
    bus.i_start = 1'b0;
    chk("busy_after_start", int'(bus.o_busy), 1);
    chk("valid_t1", int'(bus.o_valid), 0);
    tick();
    n = 2;
    chk("valid_t2", int'(bus.o_valid), 0);
    tick();
    n = 3;
    chk("valid_t3", int'(bus.o_valid), 1);
    while (!bus.o_done && n < 20000) begin
      bus.i_ready = ($urandom_range(99) >= low_pct);
      bus.i_start = poke && (n % 97 == 0);
      bus.i_inv   = ~inv;
      tick();
      n++;
    end
    bus.i_start = 1'b0;
    bus.i_ready = 1'b1;
    chk("done_seen", int'(bus.o_done), 1);
    if (low_pct == 0) chk("done_cycle", n, 899);
    tick();
    chk("done_count", done_cnt - done0, 1);
    chk("beats_total", beat_idx, BEATS);
    chk("queue_drained", exp_q.size(), 0);
    if (!inv) begin
      chk("ntt_beat0", seen_z[0], 1729);
      chk("ntt_beat127", seen_z[127], 1729);
      chk("ntt_beat128", seen_z[128], 2580);
      chk("ntt_beat192", seen_z[192], 3289);
      chk("ntt_beat895", seen_z[895], 2154);
    end else begin
      chk("intt_beat0", seen_z[0], 3312);
      chk("intt_beat1", seen_z[1], 3312);
      chk("intt_beat768", seen_z[768], 1600);
      chk("intt_beat895", seen_z[895], 1600);
    end
  endtask

  task automatic run_to_beat300();
    load_sched(1'b0);
    bus.i_start = 1'b1;
    bus.i_inv   = 1'b0;
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 5000 && beat_idx < 300; i++) tick();
    chk("reach_beat300", beat_idx, 300);
  endtask

  initial begin
    int done0, n;
    reset        = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_inv    = 1'b0;
    bus.i_abort  = 1'b0;
    bus.i_ready  = 1'b1;
    bus2.i_start = 1'b0;
    bus2.i_inv   = 1'b0;
    bus2.i_abort = 1'b0;
    bus2.i_ready = 1'b1;
`ifdef ZETA_RAW_PORT_EN
    bus.i_raw_req   = 1'b0;
    bus.i_raw_addr  = '0;
    bus2.i_raw_req  = 1'b0;
    bus2.i_raw_addr = '0;
`endif
    repeat (3) tick();
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_zeta", int'(bus.o_zeta), 0);
    chk("rst_k", int'(bus.o_k), 0);
    chk("rst_layer", int'(bus.o_layer), 0);
    chk("rst_last", int'(bus.o_last), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_done", int'(bus.o_done), 0);
    reset = 1'b0;
    tick();

    // LANES=2 instance, full NTT with ready high
    bus2.i_start = 1'b1;
    tick();
    bus2.i_start = 1'b0;
    n = 0;
    while (!bus2.o_done && n < 3000) begin
      tick();
      n++;
    end
    chk("l2_done_seen", int'(bus2.o_done), 1);
    chk("l2_beats", cnt2, 448);
    chk("l2_first_zeta", z2_first, 1729);
    chk("l2_last_zeta", z2_last, 2154);
    tick();

    run_full(1'b0, 0, 1'b0);
    run_full(1'b1, 0, 1'b0);
    run_full(1'b0, 40, 1'b1);

    // abort and start together in IDLE: abort wins
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    chk("abort_wins_busy", int'(bus.o_busy), 0);
    tick();
    tick();
    chk("abort_wins_valid", int'(bus.o_valid), 0);

    // abort mid-transform
    done0 = done_cnt;
    run_to_beat300();
    bus.i_abort = 1'b1;
    bus.i_ready = 1'b0;
    exp_q.delete();
    tick();
    chk("abort_valid", int'(bus.o_valid), 0);
    chk("abort_busy", int'(bus.o_busy), 0);
    bus.i_abort = 1'b0;
    bus.i_ready = 1'b1;
    repeat (5) tick();
    chk("abort_idle_valid", int'(bus.o_valid), 0);
    chk("abort_no_done", done_cnt - done0, 0);
    run_full(1'b0, 0, 1'b0);

    // asynchronous reset mid-transform
    done0 = done_cnt;
    run_to_beat300();
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("areset_valid", int'(bus.o_valid), 0);
    chk("areset_zeta", int'(bus.o_zeta), 0);
    chk("areset_k", int'(bus.o_k), 0);
    chk("areset_layer", int'(bus.o_layer), 0);
    chk("areset_last", int'(bus.o_last), 0);
    chk("areset_busy", int'(bus.o_busy), 0);
    chk("areset_done", int'(bus.o_done), 0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("areset_no_done", done_cnt - done0, 0);
    chk("areset_idle_valid", int'(bus.o_valid), 0);

`ifdef ZETA_RAW_PORT_EN
    bus.i_raw_req  = 1'b1;
    bus.i_raw_addr = 8'd3;
    tick();
    bus.i_raw_req = 1'b0;
    chk("raw3_valid_t1", int'(bus.o_raw_valid), 0);
    tick();
    chk("raw3_valid_t2", int'(bus.o_raw_valid), 1);
    chk("raw3_zeta", int'(bus.o_raw_zeta), 1584);
    bus.i_raw_req  = 1'b1;
    bus.i_raw_addr = 8'd128;
    tick();
    bus.i_raw_req = 1'b0;
    tick();
    chk("raw128_valid", int'(bus.o_raw_valid), 1);
    chk("raw128_zeta", int'(bus.o_raw_zeta), 3328);
    fork
      run_full(1'b0, 0, 1'b0);
      begin
        repeat (50) tick();
        bus.i_raw_req  = 1'b1;
        bus.i_raw_addr = 8'd5;
        tick();
        bus.i_raw_req = 1'b0;
        chk("raw_err_pulse", int'(bus.o_raw_err), 1);
        tick();
        chk("raw_err_clear", int'(bus.o_raw_err), 0);
        chk("raw_busy_no_valid", int'(bus.o_raw_valid), 0);
      end
    join
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
